cam_capture_dec: RTL and testbench

Parametrised successor to the existing OV7670 capture path, running entirely in the camera pixel-clock domain.
- Assembles byte pairs from the sensor bus into 16-bit pixels.
- Optionally decimates by 2^DEC_LOG2 in both axes.
- Converts YUV422 luma to RGB565 grey.
- Generates frame-buffer write address and strobe.
- Adds single-shot/continuous arming, frame counting and error flags.
- Feeds port A of the dual-port frame buffer; VGA reads port B.

---
 rtl/cam_capture_dec.sv | 173 +++++++++++++++++
 tb/tb_cam_capture_dec.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cam_capture_dec.sv
// Camera capture path in the pixel-clock domain: byte pairing, 2^DEC_LOG2
// decimation, optional luma-to-grey conversion and frame-buffer write port A.
// Optional feature macro: CAP_CHECKSUM_EN adds a per-frame write-data checksum.
module cam_capture_dec #(
    parameter int unsigned H_ACTIVE = 640,
    parameter int unsigned V_ACTIVE = 480,
    parameter int unsigned DEC_LOG2 = 1,
    parameter int unsigned ADDR_W   = 17
) (
    input  logic              pclk,
    input  logic              rst,
    input  logic              vsync,
    input  logic              href,
    input  logic [7:0]        d,
    input  logic              arm,
    input  logic              continuous,
    input  logic              gray,
    output logic [ADDR_W-1:0] addr,
    output logic [15:0]       dout,
    output logic              we,
    output logic              busy,
    output logic              frame_done,
    output logic [7:0]        frame_cnt,
    output logic [ADDR_W-1:0] words,
    output logic              err_len,
`ifdef CAP_CHECKSUM_EN
    output logic              err_ovf,
    output logic [15:0]       checksum
`else
    output logic              err_ovf
`endif
);

    localparam int unsigned FRAME_PIX = (H_ACTIVE >> DEC_LOG2) * (V_ACTIVE >> DEC_LOG2);
    // Never write past the buffer even if the parameters disagree with it.
    localparam int unsigned ADDR_CAP  = (FRAME_PIX > (1 << ADDR_W)) ? (1 << ADDR_W) : FRAME_PIX;
    localparam int unsigned FW        = ADDR_W + 1;
    localparam int unsigned CW        = $clog2(H_ACTIVE + 2);
    localparam int unsigned RW        = $clog2(V_ACTIVE + 1);
    localparam int unsigned DEC_MASK  = (1 << DEC_LOG2) - 1;

    typedef enum logic [1:0] {IDLE, ARMED, CAPTURE} state_t;

    state_t        state;
    logic          vs_q;
    logic          hr_q;
    logic          phase;
    logic          gray_q;
    logic [7:0]    hi;
    logic [CW-1:0] col;     // saturates at H_ACTIVE+1 so overlong lines stay visible
    logic [RW-1:0] row;     // saturates at V_ACTIVE
    logic [FW-1:0] wcnt;    // one extra bit so a full buffer is representable

    logic          fs;
    logic          fe;
    logic          le;
    logic          keep;
    logic          full;
    logic [15:0]   pix;

    // Sync edges, keep/full qualification and pixel formatting.
    assign fs   = vs_q & ~vsync;
    assign fe   = ~vs_q & vsync;
    assign le   = hr_q & ~href;
    assign keep = ((32'(col) & DEC_MASK) == 32'd0) && ((32'(row) & DEC_MASK) == 32'd0)
               && (32'(col) < H_ACTIVE) && (32'(row) < V_ACTIVE);
    assign full = 32'(wcnt) >= ADDR_CAP;
    assign pix  = gray_q ? {hi[7:3], hi[7:2], hi[7:3]} : {hi, d};
    assign addr = wcnt[ADDR_W-1:0];

    // Capture FSM with byte pairing, counters, write strobe and status flags.
    always_ff @(posedge pclk) begin
        if (rst) begin
            state      <= IDLE;
            vs_q       <= 1'b0;
            hr_q       <= 1'b0;
            phase      <= 1'b0;
            gray_q     <= 1'b0;
            hi         <= '0;
            col        <= '0;
            row        <= '0;
            wcnt       <= '0;
            dout       <= '0;
            we         <= 1'b0;
            busy       <= 1'b0;
            frame_done <= 1'b0;
            frame_cnt  <= '0;
            words      <= '0;
            err_len    <= 1'b0;
            err_ovf    <= 1'b0;
        end else begin
            vs_q       <= vsync;
            hr_q       <= href;
            we         <= 1'b0;
            frame_done <= 1'b0;
            if (we) wcnt <= wcnt + FW'(1);
            case (state)
                IDLE: begin
                    if (arm) begin
                        state   <= ARMED;
                        busy    <= 1'b1;
                        err_len <= 1'b0;
                        err_ovf <= 1'b0;
                    end
                end
                ARMED: begin
                    if (fs) begin
                        state  <= CAPTURE;
                        wcnt   <= '0;
                        col    <= '0;
                        row    <= '0;
                        phase  <= 1'b0;
                        gray_q <= gray;
                    end
                end
                CAPTURE: begin
                    if (href) begin
                        phase <= ~phase;
                        if (!phase) begin
                            hi <= d;
                        end else begin
                            if (col <= CW'(H_ACTIVE)) col <= col + CW'(1);
                            if (keep) begin
                                if (full) begin
                                    err_ovf <= 1'b1;
                                end else begin
                                    we   <= 1'b1;
                                    dout <= pix;
                                end
                            end
                        end
                    end else begin
                        phase <= 1'b0;
                    end
                    if (le) begin
                        if (col != CW'(H_ACTIVE)) err_len <= 1'b1;
                        col <= '0;
                        if (row < RW'(V_ACTIVE)) row <= row + RW'(1);
                    end
                    if (fe) begin
                        frame_done <= 1'b1;
                        words      <= ADDR_W'(wcnt + FW'(we));
                        frame_cnt  <= frame_cnt + 8'd1;
                        if (continuous) begin
                            state <= ARMED;
                        end else begin
                            state <= IDLE;
                            busy  <= 1'b0;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef CAP_CHECKSUM_EN
    logic [15:0] csum_acc;

    // Running sum of written pixels, published with frame_done.
    always_ff @(posedge pclk) begin
        if (rst) begin
            csum_acc <= '0;
            checksum <= '0;
        end else begin
            if (state == ARMED && fs) csum_acc <= '0;
            else if (we)              csum_acc <= csum_acc + dout;
            if (state == CAPTURE && fe) checksum <= csum_acc + (we ? dout : 16'd0);
        end
    end
`endif

endmodule

// File: tb/tb_cam_capture_dec.sv
// Directed bench for cam_capture_dec: a decimating instance (A) and a
// non-decimating instance whose buffer is smaller than the frame (B).
module tb_cam_capture_dec;

    localparam int unsigned HA = 16, VA = 8, DA = 1, AWA = 6;
    localparam int unsigned HB = 8,  VB = 4, DB = 0, AWB = 4;
    localparam int unsigned KWA = HA >> DA;

    logic pclk = 1'b0;
    logic rst = 1'b1, arm = 1'b0, continuous = 1'b0, gray = 1'b0;
    logic vs_a = 1'b1, hr_a = 1'b0, vs_b = 1'b1, hr_b = 1'b0;
    logic [7:0] d_a = '0, d_b = '0;

    logic [AWA-1:0] addr_a, words_a;
    logic [AWB-1:0] addr_b, words_b;
    logic [15:0] dout_a, dout_b;
    logic we_a, busy_a, fd_a, el_a, eo_a, we_b, busy_b, fd_b, el_b, eo_b;
    logic [7:0] fc_a, fc_b;
`ifdef CAP_CHECKSUM_EN
    logic [15:0] cs_a, cs_b;
`endif

    always #5 pclk = ~pclk;

    cam_capture_dec #(.H_ACTIVE(HA), .V_ACTIVE(VA), .DEC_LOG2(DA), .ADDR_W(AWA)) dut_a (
        .pclk(pclk), .rst(rst), .vsync(vs_a), .href(hr_a), .d(d_a), .arm(arm),
        .continuous(continuous), .gray(gray), .addr(addr_a), .dout(dout_a), .we(we_a),
        .busy(busy_a), .frame_done(fd_a), .frame_cnt(fc_a), .words(words_a),
`ifdef CAP_CHECKSUM_EN
        .err_len(el_a), .err_ovf(eo_a), .checksum(cs_a));
`else
        .err_len(el_a), .err_ovf(eo_a));
`endif

    cam_capture_dec #(.H_ACTIVE(HB), .V_ACTIVE(VB), .DEC_LOG2(DB), .ADDR_W(AWB)) dut_b (
        .pclk(pclk), .rst(rst), .vsync(vs_b), .href(hr_b), .d(d_b), .arm(arm),
        .continuous(continuous), .gray(gray), .addr(addr_b), .dout(dout_b), .we(we_b),
        .busy(busy_b), .frame_done(fd_b), .frame_cnt(fc_b), .words(words_b),
`ifdef CAP_CHECKSUM_EN
        .err_len(el_b), .err_ovf(eo_b), .checksum(cs_b));
`else
        .err_len(el_b), .err_ovf(eo_b));
`endif

    int nchecks = 0, nerrors = 0;
    int pat_mode = 0;
    logic [7:0] pat_hi = '0, pat_lo = '0;
    logic chk_pat = 1'b0;
    logic mon_clr = 1'b0;
    logic le_err [0:15];

    int we_cnt_a, exp_addr_a, addr_bad_a, dout_bad_a, fd_cnt_a, busy_low_a;
    int we_cnt_b, exp_addr_b, addr_bad_b, fd_cnt_b, ovf_at_b;
    logic ovf_seen_b;

    // Write/pulse monitor for instance A.
    always @(negedge pclk) begin
        if (mon_clr) begin
            we_cnt_a <= 0; exp_addr_a <= 0; addr_bad_a <= 0; dout_bad_a <= 0;
            fd_cnt_a <= 0; busy_low_a <= 0;
        end else begin
            if (we_a) begin
                we_cnt_a   <= we_cnt_a + 1;
                exp_addr_a <= exp_addr_a + 1;
                if (int'(addr_a) != exp_addr_a) addr_bad_a <= addr_bad_a + 1;
                if (chk_pat && dout_a !== {8'((exp_addr_a / KWA) << DA), 8'((exp_addr_a % KWA) << DA)})
                    dout_bad_a <= dout_bad_a + 1;
            end
            if (fd_a) fd_cnt_a <= fd_cnt_a + 1;
            if (!busy_a) busy_low_a <= busy_low_a + 1;
        end
    end

    // Write/pulse monitor for instance B.
    always @(negedge pclk) begin
        if (mon_clr) begin
            we_cnt_b <= 0; exp_addr_b <= 0; addr_bad_b <= 0; fd_cnt_b <= 0;
            ovf_at_b <= -1; ovf_seen_b <= 1'b0;
        end else begin
            if (we_b) begin
                we_cnt_b   <= we_cnt_b + 1;
                exp_addr_b <= exp_addr_b + 1;
                if (int'(addr_b) != exp_addr_b) addr_bad_b <= addr_bad_b + 1;
            end
            if (fd_b) fd_cnt_b <= fd_cnt_b + 1;
            if (eo_b && !ovf_seen_b) begin
                ovf_seen_b <= 1'b1;
                ovf_at_b   <= we_cnt_b;
            end
        end
    end

    task automatic step();
        @(posedge pclk);
        #1;
    endtask

    task automatic drv(input int sel, input logic v, input logic h, input logic [7:0] b);
        if (sel == 0) begin vs_a = v; hr_a = h; d_a = b; end
        else          begin vs_b = v; hr_b = h; d_b = b; end
    endtask

    task automatic do_reset();
        rst = 1'b1; step(); step(); rst = 1'b0;
        mon_clr = 1'b1; step(); mon_clr = 1'b0;
    endtask

    task automatic pulse_arm();
        arm = 1'b1; step(); arm = 1'b0;
    endtask

    // Blanking, vsync fall, nlines lines, then vsync rise.
    task automatic run_frame(input int sel, input int nlines, input int npairs,
                             input int odd_line, input int odd_pairs);
        int n;
        logic [7:0] bh, bl;
        drv(sel, 1'b1, 1'b0, 8'h00); repeat (3) step();
        drv(sel, 1'b0, 1'b0, 8'h00); step(); step();
        for (int l = 0; l < nlines; l++) begin
            n = (l == odd_line) ? odd_pairs : npairs;
            for (int c = 0; c < n; c++) begin
                bh = (pat_mode == 0) ? 8'(l) : pat_hi;
                bl = (pat_mode == 0) ? 8'(c) : pat_lo;
                drv(sel, 1'b0, 1'b1, bh); step();
                drv(sel, 1'b0, 1'b1, bl); step();
            end
            drv(sel, 1'b0, 1'b0, 8'h00); step();
            if (l < 16) le_err[l] = (sel == 0) ? el_a : el_b;
            step(); step();
        end
        drv(sel, 1'b1, 1'b0, 8'h00); step(); step();
    endtask

    task automatic test_reset();
        do_reset();
        nchecks++; if ({addr_a, dout_a, we_a, busy_a, fd_a} !== '0) begin nerrors++;
            $display("FAIL reset_outs_a: got %0h exp 0", {addr_a, dout_a, we_a, busy_a, fd_a}); end
        nchecks++; if ({fc_a, words_a, el_a, eo_a} !== '0) begin nerrors++;
            $display("FAIL reset_stat_a: got %0h exp 0", {fc_a, words_a, el_a, eo_a}); end
    endtask

    task automatic test_full_frame();
        do_reset(); continuous = 1'b0; gray = 1'b0; pat_mode = 0; chk_pat = 1'b1;
        pulse_arm();
        nchecks++; if (busy_a !== 1'b1) begin nerrors++; $display("FAIL armed_busy: got %0b exp 1", busy_a); end
        run_frame(0, VA, HA, -1, 0);
        chk_pat = 1'b0;
        nchecks++; if (we_cnt_a !== 32) begin nerrors++; $display("FAIL ff_we_cnt: got %0d exp 32", we_cnt_a); end
        nchecks++; if (addr_bad_a !== 0) begin nerrors++; $display("FAIL ff_addr_seq: got %0d bad exp 0", addr_bad_a); end
        nchecks++; if (dout_bad_a !== 0) begin nerrors++; $display("FAIL ff_dout: got %0d bad exp 0", dout_bad_a); end
        nchecks++; if (fd_cnt_a !== 1) begin nerrors++; $display("FAIL ff_done: got %0d exp 1", fd_cnt_a); end
        nchecks++; if (words_a !== 6'd32) begin nerrors++; $display("FAIL ff_words: got %0d exp 32", words_a); end
        nchecks++; if (fc_a !== 8'd1) begin nerrors++; $display("FAIL ff_frame_cnt: got %0d exp 1", fc_a); end
        nchecks++; if (busy_a !== 1'b0) begin nerrors++; $display("FAIL ff_busy: got %0b exp 0", busy_a); end
        nchecks++; if ({el_a, eo_a} !== 2'b00) begin nerrors++; $display("FAIL ff_errs: got %0b exp 00", {el_a, eo_a}); end
    endtask

    task automatic test_data_path();
        do_reset(); gray = 1'b0; pulse_arm();
        drv(0, 1'b1, 1'b0, 8'h00); repeat (3) step();
        drv(0, 1'b0, 1'b0, 8'h00); step();
        drv(0, 1'b0, 1'b1, 8'hA5); step();
        nchecks++; if (we_a !== 1'b0) begin nerrors++; $display("FAIL dp_we_early: got %0b exp 0", we_a); end
        drv(0, 1'b0, 1'b1, 8'h3C); step();
        nchecks++; if (we_a !== 1'b1) begin nerrors++; $display("FAIL dp_we: got %0b exp 1", we_a); end
        nchecks++; if (dout_a !== 16'hA53C) begin nerrors++; $display("FAIL dp_rgb: got %0h exp a53c", dout_a); end
        nchecks++; if (addr_a !== 6'd0) begin nerrors++; $display("FAIL dp_addr0: got %0d exp 0", addr_a); end
        drv(0, 1'b0, 1'b1, 8'h00); step();
        nchecks++; if ({we_a, addr_a} !== {1'b0, 6'd1}) begin nerrors++;
            $display("FAIL dp_post_inc: got we=%0b addr=%0d exp we=0 addr=1", we_a, addr_a); end
        do_reset(); gray = 1'b1; pulse_arm();
        drv(0, 1'b1, 1'b0, 8'h00); repeat (3) step();
        drv(0, 1'b0, 1'b0, 8'h00); step();
        gray = 1'b0;
        drv(0, 1'b0, 1'b1, 8'h80); step();
        drv(0, 1'b0, 1'b1, 8'h11); step();
        nchecks++; if ({we_a, dout_a} !== {1'b1, 16'h8410}) begin nerrors++;
            $display("FAIL dp_gray: got we=%0b dout=%0h exp we=1 dout=8410", we_a, dout_a); end
        drv(0, 1'b1, 1'b0, 8'h00);
    endtask

    task automatic test_err_len();
        do_reset(); continuous = 1'b0; pat_mode = 0; pulse_arm();
        run_frame(0, VA, HA, 2, HA - 1);
        nchecks++; if (le_err[1] !== 1'b0) begin nerrors++; $display("FAIL el_before: got %0b exp 0", le_err[1]); end
        nchecks++; if (le_err[2] !== 1'b1) begin nerrors++; $display("FAIL el_at_line: got %0b exp 1", le_err[2]); end
        nchecks++; if ({el_a, fd_cnt_a} !== {1'b1, 32'd1}) begin nerrors++;
            $display("FAIL el_sticky: got el=%0b done=%0d exp el=1 done=1", el_a, fd_cnt_a); end
        nchecks++; if (words_a !== 6'd32) begin nerrors++; $display("FAIL el_words: got %0d exp 32", words_a); end
        pulse_arm();
        nchecks++; if (el_a !== 1'b0) begin nerrors++; $display("FAIL el_clear: got %0b exp 0", el_a); end
    endtask

    task automatic test_out_of_range();
        do_reset(); continuous = 1'b0; pulse_arm();
        run_frame(0, VA + 2, HA, -1, 0);
        nchecks++; if ({we_cnt_a, words_a} !== {32'd32, 6'd32}) begin nerrors++;
            $display("FAIL oor_lines: got we=%0d words=%0d exp 32/32", we_cnt_a, words_a); end
        nchecks++; if ({el_a, eo_a} !== 2'b00) begin nerrors++; $display("FAIL oor_errs: got %0b exp 00", {el_a, eo_a}); end
        do_reset(); pulse_arm();
        run_frame(0, VA, HA, 3, HA + 2);
        nchecks++; if ({we_cnt_a, el_a} !== {32'd32, 1'b1}) begin nerrors++;
            $display("FAIL oor_long: got we=%0d el=%0b exp 32/1", we_cnt_a, el_a); end
        do_reset(); pulse_arm();
        run_frame(1, VB, HB, -1, 0);
        nchecks++; if (we_cnt_b !== 16) begin nerrors++; $display("FAIL ovf_we_cnt: got %0d exp 16", we_cnt_b); end
        nchecks++; if (addr_bad_b !== 0) begin nerrors++; $display("FAIL ovf_addr_seq: got %0d bad exp 0", addr_bad_b); end
        nchecks++; if (ovf_at_b !== 16) begin nerrors++; $display("FAIL ovf_first: got %0d exp 16", ovf_at_b); end
        nchecks++; if ({eo_b, el_b, fc_b} !== {1'b1, 1'b0, 8'd1}) begin nerrors++;
            $display("FAIL ovf_flags: got %0h exp 201", {eo_b, el_b, fc_b}); end
    endtask

    task automatic test_continuous();
        drv(0, 1'b0, 1'b0, 8'h00);
        do_reset(); continuous = 1'b1; pat_mode = 0;
        for (int c = 0; c < 4; c++) begin drv(0, 1'b0, 1'b1, 8'(c)); step(); end
        pulse_arm();
        for (int c = 0; c < 6; c++) begin drv(0, 1'b0, 1'b1, 8'(c)); step(); end
        drv(0, 1'b0, 1'b0, 8'h00); step();
        drv(0, 1'b1, 1'b0, 8'h00); step(); step();
        nchecks++; if ({we_cnt_a, fd_cnt_a} !== 64'd0) begin nerrors++;
            $display("FAIL cont_skip: got we=%0d done=%0d exp 0/0", we_cnt_a, fd_cnt_a); end
        mon_clr = 1'b1; step(); mon_clr = 1'b0;
        for (int f = 0; f < 3; f++) run_frame(0, VA, HA, -1, 0);
        nchecks++; if ({fc_a, fd_cnt_a, we_cnt_a} !== {8'd3, 32'd3, 32'd96}) begin nerrors++;
            $display("FAIL cont_3: got cnt=%0d done=%0d we=%0d exp 3/3/96", fc_a, fd_cnt_a, we_cnt_a); end
        nchecks++; if (busy_low_a !== 0) begin nerrors++; $display("FAIL cont_busy: got %0d low cycles exp 0", busy_low_a); end
        continuous = 1'b0;
        run_frame(0, VA, HA, -1, 0);
        nchecks++; if ({fc_a, busy_a} !== {8'd4, 1'b0}) begin nerrors++;
            $display("FAIL cont_stop: got cnt=%0d busy=%0b exp 4/0", fc_a, busy_a); end
        do_reset(); continuous = 1'b1; pulse_arm();
        for (int f = 0; f < 255; f++) run_frame(1, 1, 1, -1, 0);
        nchecks++; if (fc_b !== 8'd255) begin nerrors++; $display("FAIL wrap_255: got %0d exp 255", fc_b); end
        run_frame(1, 1, 1, -1, 0);
        nchecks++; if ({fc_b, fd_cnt_b} !== {8'd0, 32'd256}) begin nerrors++;
            $display("FAIL wrap_0: got cnt=%0d done=%0d exp 0/256", fc_b, fd_cnt_b); end
        continuous = 1'b0;
    endtask

    task automatic test_reset_mid_line();
        do_reset(); continuous = 1'b0; pulse_arm();
        drv(0, 1'b1, 1'b0, 8'h00); repeat (3) step();
        drv(0, 1'b0, 1'b0, 8'h00); step();
        for (int c = 0; c < 7; c++) begin drv(0, 1'b0, 1'b1, 8'h5A); step(); end
        nchecks++; if (we_cnt_a !== 2) begin nerrors++; $display("FAIL rml_pre_we: got %0d exp 2", we_cnt_a); end
        rst = 1'b1; step();
        nchecks++; if ({addr_a, dout_a, we_a, busy_a, fd_a, fc_a, words_a, el_a, eo_a} !== '0) begin nerrors++;
            $display("FAIL rml_outs: got %0h exp 0", {addr_a, dout_a, we_a, busy_a, fd_a, fc_a, words_a, el_a, eo_a}); end
        rst = 1'b0;
        drv(0, 1'b0, 1'b1, 8'h5A); step();
        drv(0, 1'b0, 1'b0, 8'h00); step();
        drv(0, 1'b1, 1'b0, 8'h00); step(); step();
        nchecks++; if ({fd_cnt_a, busy_a, fc_a} !== {32'd0, 1'b0, 8'd0}) begin nerrors++;
            $display("FAIL rml_no_done: got done=%0d busy=%0b cnt=%0d exp 0/0/0", fd_cnt_a, busy_a, fc_a); end
    endtask

`ifdef CAP_CHECKSUM_EN
    task automatic test_checksum();
        do_reset(); pat_mode = 1; pat_hi = 8'h00; pat_lo = 8'h01; pulse_arm();
        nchecks++; if (cs_a !== 16'h0000) begin nerrors++; $display("FAIL cs_reset: got %0h exp 0", cs_a); end
        run_frame(0, VA, HA, -1, 0);
        nchecks++; if (cs_a !== 16'h0020) begin nerrors++; $display("FAIL cs_value: got %0h exp 0020", cs_a); end
        pat_mode = 0;
    endtask
`endif

    initial begin
        test_reset();
        test_full_frame();
        test_data_path();
        test_err_len();
        test_out_of_range();
        test_continuous();
        test_reset_mid_line();
`ifdef CAP_CHECKSUM_EN
        test_checksum();
`endif
        $display("Simulation finished: %0d checks, %0d errors", nchecks, nerrors);
        $finish;
    end

endmodule
